vram_text_arbiter: RTL and testbench
====================================

Name: vram_text_arbiter

Overview:
- Shares one synchronous single-port character RAM (80x30 text cells) between two masters.
- Display fetch: the text-mode scanout, driven by the free-running VGA pixel counters (X 0..800, Y 0..525). Fixed priority; never stalled.
- Host port: CPU/UART writer with req/ack handshake, served in every RAM cycle the display does not need.
- Sits between the sync/counter generator and the glyph ROM/pixel serializer.

Parameters:
- COLS, 80: text columns per row.
- ROWS, 30: text rows.
- H_VISIBLE, 640: visible pixels per line.
- V_VISIBLE, 480: visible lines per frame.
- ADDR_W, 12: RAM address width; must cover COLS*ROWS.
- DATA_W, 8: character code width.
- Glyph cell is fixed at 8x16 pixels (shift constants, not parameters).

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst  in  1  asynchronous, active-high reset.
- counter_x  in  10  pixel X from the sync generator.
- counter_y  in  9  line Y from the sync generator.
- host_req  in  1  host operation request; hold with addr/data stable until ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  cell address.
- host_wdata  in  DATA_W  write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_W  read data, valid while host_ack = 1 and held until the next read completes.
- ram_en  out  1  RAM cycle enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, one-cycle latency.
- char_code  out  DATA_W  fetched character for the current cell.
- glyph_row  out  4  counter_y[3:0], aligned with char_code.
- char_valid  out  1  one-cycle strobe: new char_code and glyph_row present.

Behaviour:
- Reset (async assert, sync deassert via clk): host_ack=0, host_rdata=0, char_code=0, glyph_row=0, char_valid=0, FSM=IDLE, owner tag=NONE. RAM outputs are 0 while in reset.
- disp_slot = (counter_x < H_VISIBLE) && (counter_y < V_VISIBLE) && (counter_x[2:0] == 0).
- Display address = (counter_y[8:4] * COLS) + counter_x[9:3]. Computed with shifts/adds, (row<<6)+(row<<4)+col. Max 2399; no overflow in ADDR_W.
- In a disp_slot cycle: ram_en=1, ram_we=0, display address driven; owner tag <= DISP.
- Next cycle (phase 1): char_code <= ram_rdata, glyph_row <= registered counter_y[3:0], char_valid <= 1.
- char_valid is high at phase 2 only: a 2-cycle latency from the slot. Downstream delays sync by the same amount.
- Outside the visible area: no display fetches, char_valid stays 0, char_code holds its last value.
- Host FSM:
  - IDLE: if host_req && !disp_slot, drive RAM with the host op (ram_en=1, ram_we=host_we and in-range), owner tag <= HOST, go to WAIT. If disp_slot, stay in IDLE; the display wins.
  - WAIT: capture ram_rdata into host_rdata if the op was a read; go to ACK.
  - ACK: host_ack=1; go to IDLE. host_req is not examined in ACK or WAIT.
- Host latency: 2 cycles from issue to ack. Worst-case wait before issue is 1 cycle, because phase 1 is never a disp_slot. Back-to-back throughput is one op per 3 cycles.
- Host deasserts or changes req at the edge where it samples ack. If req stays high, the next op issues in the following IDLE cycle.
- Out-of-range host_addr (>= COLS*ROWS):
  - Write: suppressed (ram_en=0), still acked.
  - Read: no RAM access, host_rdata=0, still acked.
- Owner tag steers ram_rdata to exactly one of char_code or host_rdata. A display fetch never corrupts host_rdata, and the reverse also holds.
- Reset mid-operation: any in-flight host op is dropped with no ack. If host_req is still high after reset, the op is re-issued.
- Counter wrap (X 800->0, Y 525->0): no special handling; fetching resumes at the next visible phase-0 cycle.

Decomposition:
- Package vram_text_pkg holds:
  - constants COLS, ROWS, CELL_W_LOG2=3, CELL_H_LOG2=4, H_VISIBLE, V_VISIBLE;
  - FSM state enum {IDLE, WAIT, ACK};
  - owner enum {NONE, DISP, HOST}.
- Sub-module text_addr_calc: combinational row*80+col address plus the disp_slot decode, reusable by the glyph pipeline.

Test Plan:
- Reset, then free-run counters. Expect a display read at x=0,y=0 with addr 0, char_valid at x=2, and at y=479, x=632: addr 29*80+79=2399.
- Host write addr 5, data 0x41, requested at x=8 (disp_slot) -> RAM write at x=9, ack at x=11. A later read of 5 returns 0x41.
- Host read with req held continuously during the visible line -> RAM never double-driven. No host issue on phase-0 cycles. Every ack spaced by 3 cycles or more.
- Host write addr 2400 -> ram_en never asserted for it, ack 2 cycles after issue. Read of 2400 -> host_rdata=0.
- Host read issued at x=7, followed by a display fetch at x=8 -> host_rdata equals the host cell and char_code equals the display cell; no swap.
- Assert rst during WAIT -> no ack, all outputs 0. After release with req high -> op re-issued and acked exactly once.

Source files
------------

// File: rtl/vram_text_pkg.sv
// Shared constants and enumerations for the text-mode VRAM arbiter.
// The glyph cell geometry is fixed at 8x16 pixels, so it is expressed as
// shift amounts rather than as parameters.
package vram_text_pkg;

    localparam int COLS        = 80;
    localparam int ROWS        = 30;
    localparam int CELL_W_LOG2 = 3;
    localparam int CELL_H_LOG2 = 4;
    localparam int H_VISIBLE   = 640;
    localparam int V_VISIBLE   = 480;
    localparam int NUM_CELLS   = COLS * ROWS;

    // Host transaction sequencer: issue in IDLE, read data returns in WAIT,
    // completion is signalled in ACK.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } host_state_e;

    // Which master drove the RAM in the previous cycle, i.e. who owns the
    // read data appearing on ram_rdata in the current cycle.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        DISP = 2'd1,
        HOST = 2'd2
    } owner_e;

endpackage

// File: rtl/text_addr_calc.sv
// Combinational decode of the scanout position into a character-cell address
// and a display-slot flag. The slot is the first pixel of each visible cell;
// the row multiply by 80 is built from two shifts and an add.
module text_addr_calc
    import vram_text_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int H_VIS  = H_VISIBLE,
    parameter int V_VIS  = V_VISIBLE
) (
    input  logic [9:0]        counter_x,
    input  logic [8:0]        counter_y,
    output logic              disp_slot,
    output logic [ADDR_W-1:0] disp_addr
);

    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] col_ext;
    logic              x_visible;
    logic              y_visible;
    logic              cell_start;

    // Cell address is row*80 + col, formed as (row<<6)+(row<<4)+col; the
    // largest result (2399) fits comfortably in a 12-bit address.
    always_comb begin
        row_ext    = ADDR_W'(counter_y[8:CELL_H_LOG2]);
        col_ext    = ADDR_W'(counter_x[9:CELL_W_LOG2]);
        disp_addr  = (row_ext << 6) + (row_ext << 4) + col_ext;
        x_visible  = (counter_x < 10'(H_VIS));
        y_visible  = (counter_y < 9'(V_VIS));
        cell_start = (counter_x[CELL_W_LOG2-1:0] == '0);
        disp_slot  = x_visible && y_visible && cell_start;
    end

endmodule

// File: rtl/vram_text_arbiter.sv
// Shares one synchronous single-port character RAM between the text scanout
// (fixed priority, never stalled) and a req/ack host port that takes every
// RAM cycle the scanout does not need. An owner tag remembers who drove the
// RAM last cycle so that the returning read data is steered to exactly one
// consumer.
module vram_text_arbiter #(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        counter_x,
    input  logic [8:0]        counter_y,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] char_code,
    output logic [3:0]        glyph_row,
    output logic              char_valid
);

    import vram_text_pkg::*;

    localparam int CELL_COUNT = COLS * ROWS;

    logic              disp_slot;
    logic [ADDR_W-1:0] disp_addr;
    logic              host_in_range;
    logic              host_issue;

    host_state_e       state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              op_read_q, op_read_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [DATA_W-1:0] char_code_q, char_code_d;
    logic [3:0]        glyph_row_q, glyph_row_d;
    logic [3:0]        slot_row_q, slot_row_d;
    logic              char_valid_q, char_valid_d;

    text_addr_calc #(
        .ADDR_W (ADDR_W),
        .H_VIS  (H_VISIBLE),
        .V_VIS  (V_VISIBLE)
    ) u_addr_calc (
        .counter_x (counter_x),
        .counter_y (counter_y),
        .disp_slot (disp_slot),
        .disp_addr (disp_addr)
    );

    // A host op may only start from IDLE and only when the scanout does not
    // claim this cycle; out-of-range addresses never reach the RAM.
    always_comb begin
        host_in_range = (host_addr < ADDR_W'(CELL_COUNT));
        host_issue    = (state_q == IDLE) && host_req && !disp_slot;
    end

    // RAM port mux: scanout first, then a host op; everything quiet in reset.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) begin
            if (disp_slot) begin
                ram_en   = 1'b1;
                ram_addr = disp_addr;
            end else if (host_issue && host_in_range) begin
                ram_en    = 1'b1;
                ram_we    = host_we;
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
            end
        end
    end

    // Host sequencer next-state and read-data capture; the request line is
    // ignored outside IDLE so the host can change it at the ack edge.
    always_comb begin
        state_d      = state_q;
        op_read_d    = op_read_q;
        host_rdata_d = host_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (host_issue) begin
                    state_d   = WAIT;
                    op_read_d = !host_we;
                end
            end
            WAIT: begin
                if (op_read_q) begin
                    host_rdata_d = (owner_q == HOST) ? ram_rdata : '0;
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Owner tag for the read data that will return next cycle.
    always_comb begin
        owner_d = NONE;
        if (disp_slot) begin
            owner_d = DISP;
        end else if (host_issue && host_in_range) begin
            owner_d = HOST;
        end
    end

    // Scanout pipeline: remember the glyph row at the slot, then capture the
    // returned character together with that row one cycle later.
    always_comb begin
        char_code_d  = char_code_q;
        glyph_row_d  = glyph_row_q;
        char_valid_d = 1'b0;
        slot_row_d   = slot_row_q;
        if (disp_slot) begin
            slot_row_d = counter_y[CELL_H_LOG2-1:0];
        end
        if (owner_q == DISP) begin
            char_code_d  = ram_rdata;
            glyph_row_d  = slot_row_q;
            char_valid_d = 1'b1;
        end
    end

    // State and pipeline registers; reset drops any in-flight host op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= NONE;
            op_read_q    <= 1'b0;
            host_rdata_q <= '0;
            char_code_q  <= '0;
            glyph_row_q  <= '0;
            slot_row_q   <= '0;
            char_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            op_read_q    <= op_read_d;
            host_rdata_q <= host_rdata_d;
            char_code_q  <= char_code_d;
            glyph_row_q  <= glyph_row_d;
            slot_row_q   <= slot_row_d;
            char_valid_q <= char_valid_d;
        end
    end

    // Registered outputs; the ack pulse is simply the ACK state.
    always_comb begin
        host_ack   = (state_q == ACK);
        host_rdata = host_rdata_q;
        char_code  = char_code_q;
        glyph_row  = glyph_row_q;
        char_valid = char_valid_q;
    end

endmodule

// File: tb/tb_vram_text_arbiter.sv
// Self-checking bench for vram_text_arbiter. A behavioural RAM sits on the
// RAM port; a cycle-indexed reference model predicts every RAM access, the
// char_valid/char_code/glyph_row stream and each host ack/read result.
module tb_vram_text_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int NCELL  = 2400;

    logic              clk = 1'b0;
    logic              rst;
    logic [9:0]        counter_x;
    logic [8:0]        counter_y;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] char_code;
    logic [3:0]        glyph_row;
    logic              char_valid;

    vram_text_arbiter #(
        .COLS(80), .ROWS(30), .H_VISIBLE(640), .V_VISIBLE(480),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst),
        .counter_x(counter_x), .counter_y(counter_y),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .char_code(char_code), .glyph_row(glyph_row), .char_valid(char_valid)
    );

    always #20 clk = ~clk;

    // Power-up contents of a cell that has never been written.
    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    // Synchronous single-port RAM with one-cycle read latency.
    logic [7:0] mem [0:4095];
    bit         written [0:4095];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= written[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
            end
        end
    end

    // Reference model state.
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         next_free = 0;
    int         ack_cyc = -1;
    bit         pend_read = 1'b0;
    logic [7:0] pend_rdata = '0;
    logic [7:0] model_rdata = '0;
    logic [7:0] last_code = '0;
    logic [3:0] last_row = '0;
    bit         cv_sched [4];
    logic [7:0] code_sched [4];
    logic [3:0] row_sched [4];
    logic [7:0] shadow [0:NCELL-1];
    bit         saw_ack = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Predict this cycle from the current inputs and compare all outputs.
    task automatic model_step();
        bit slot;
        bit exp_en;
        bit exp_we;
        int exp_addr;
        int exp_wd;
        int a;
        int s;
        s = cyc % 4;
        exp_en = 1'b0;
        exp_we = 1'b0;
        exp_addr = 0;
        exp_wd = 0;
        saw_ack = host_ack;
        if (rst) begin
            next_free = 0;
            ack_cyc = -1;
            model_rdata = '0;
            last_code = '0;
            last_row = '0;
            for (int i = 0; i < 4; i++) cv_sched[i] = 1'b0;
            checkOutput("rst_ram_en", ram_en, 0);
            checkOutput("rst_ram_we", ram_we, 0);
            checkOutput("rst_ram_addr", ram_addr, 0);
            checkOutput("rst_ram_wdata", ram_wdata, 0);
            checkOutput("rst_host_ack", host_ack, 0);
            checkOutput("rst_host_rdata", host_rdata, 0);
            checkOutput("rst_char_valid", char_valid, 0);
            checkOutput("rst_char_code", char_code, 0);
            checkOutput("rst_glyph_row", glyph_row, 0);
            return;
        end
        slot = (counter_x < 640) && (counter_y < 480) && (counter_x % 8 == 0);
        if (slot) begin
            a = (int'(counter_y) / 16) * 80 + int'(counter_x) / 8;
            exp_en = 1'b1;
            exp_addr = a;
            cv_sched[(cyc + 2) % 4] = 1'b1;
            code_sched[(cyc + 2) % 4] = shadow[a];
            row_sched[(cyc + 2) % 4] = 4'(int'(counter_y) % 16);
        end else if (host_req && cyc >= next_free) begin
            next_free = cyc + 3;
            ack_cyc = cyc + 2;
            pend_read = !host_we;
            pend_rdata = '0;
            if (int'(host_addr) < NCELL) begin
                exp_en = 1'b1;
                exp_we = host_we;
                exp_addr = int'(host_addr);
                exp_wd = int'(host_wdata);
                if (host_we) shadow[host_addr] = host_wdata;
                else pend_rdata = shadow[host_addr];
            end
        end
        checkOutput("ram_en", ram_en, exp_en);
        if (exp_en) begin
            checkOutput("ram_addr", ram_addr, exp_addr);
            checkOutput("ram_we", ram_we, exp_we);
            if (exp_we) checkOutput("ram_wdata", ram_wdata, exp_wd);
        end
        if (cv_sched[s]) begin
            last_code = code_sched[s];
            last_row = row_sched[s];
        end
        checkOutput("char_valid", char_valid, cv_sched[s]);
        checkOutput("char_code", char_code, last_code);
        checkOutput("glyph_row", glyph_row, last_row);
        cv_sched[s] = 1'b0;
        if (cyc == ack_cyc && pend_read) model_rdata = pend_rdata;
        checkOutput("host_ack", host_ack, (cyc == ack_cyc));
        checkOutput("host_rdata", host_rdata, model_rdata);
    endtask

    // One clock: check mid-cycle, then advance the free-running counters.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (counter_x == 10'd799) begin
            counter_x = '0;
            counter_y = (counter_y == 9'd524) ? '0 : counter_y + 9'd1;
        end else begin
            counter_x = counter_x + 10'd1;
        end
    endtask

    task automatic set_pos(input int x, input int y);
        counter_x = 10'(x);
        counter_y = 9'(y);
    endtask

    // One host operation; waits (bounded) for ack, then optionally drops req.
    task automatic applyStimulus(input bit we, input int addr, input int data, input bit drop);
        int n;
        host_req = 1'b1;
        host_we = we;
        host_addr = 12'(addr);
        host_wdata = 8'(data);
        n = 0;
        do begin
            tick();
            n++;
        end while (!saw_ack && n < 20);
        checkOutput("ack_within_bound", saw_ack, 1);
        if (drop) host_req = 1'b0;
    endtask

    initial begin
        int acks;
        for (int i = 0; i < NCELL; i++) shadow[i] = init_val(i);
        for (int i = 0; i < 4; i++) cv_sched[i] = 1'b0;
        rst = 1'b1;
        host_req = 1'b0;
        host_we = 1'b0;
        host_addr = '0;
        host_wdata = '0;
        set_pos(0, 0);
        repeat (3) tick();
        rst = 1'b0;
        set_pos(0, 0);
        repeat (20) tick();

        // Bottom-right corner of the visible area, cell 2399.
        set_pos(620, 479);
        repeat (20) tick();

        // Write during a slot cycle, then read it back.
        set_pos(8, 20);
        applyStimulus(1'b1, 5, 8'h41, 1'b1);
        tick();
        applyStimulus(1'b0, 5, 0, 1'b1);

        // Back-to-back reads with req held through a visible line.
        set_pos(0, 40);
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, int'($urandom_range(0, NCELL - 1)), 0, (i == 19));
        tick();

        // Out-of-range accesses.
        applyStimulus(1'b1, 2400, 8'h5A, 1'b1);
        applyStimulus(1'b0, 2400, 0, 1'b1);
        applyStimulus(1'b1, 4095, 8'hA5, 1'b1);
        applyStimulus(1'b0, 4095, 0, 1'b1);

        // Host read at x=7 immediately followed by a display fetch at x=8.
        set_pos(200, 500);
        applyStimulus(1'b1, 321, 8'hC3, 1'b1);
        applyStimulus(1'b1, 700, 8'h3C, 1'b1);
        tick();
        set_pos(7, 64);
        applyStimulus(1'b0, 700, 0, 1'b1);
        repeat (4) tick();

        // Reset while the host op sits in WAIT; it must re-issue and ack once.
        set_pos(0, 500);
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 12'd321;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        acks = 0;
        for (int n = 0; n < 10 && acks == 0; n++) begin
            tick();
            if (saw_ack) acks++;
        end
        host_req = 1'b0;
        repeat (6) begin
            tick();
            if (saw_ack) acks++;
        end
        checkOutput("ack_once_after_reset", acks, 1);

        // Counter wrap at the end of a frame.
        set_pos(790, 524);
        repeat (30) tick();

        // Random traffic at random screen positions.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0)
                set_pos(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 2600)),
                          int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
        end
        host_req = 1'b0;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
